// File: rtl/acc_event_pack.sv
// Groups runs of flagged filter samples into event records (start, width, peak, sum, trunc)
// and queues them in a small FIFO drained over a valid/ready handshake.
module acc_event_pack #(
  parameter int unsigned MAX_WIDTH  = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        laser_start_i,
  input  logic        filter_vld_i,
  input  logic [15:0] filter_data_i,
  input  logic        filter_acc_result_i,
  output logic        event_vld_o,
  input  logic        event_ready_i,
  output logic [31:0] event_start_o,
  output logic [15:0] event_width_o,
  output logic [15:0] event_peak_o,
  output logic [31:0] event_sum_o,
  output logic        event_trunc_o,
  output logic [15:0] drop_cnt_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] MAXW_C  = 16'(MAX_WIDTH);

  typedef struct packed {
    logic [31:0] start;
    logic [15:0] width;
    logic [15:0] peak;
    logic [31:0] sum;
    logic        trunc;
  } rec_t;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HOLD} state_t;

  function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] idx_q;
  logic        laser_q;
  logic [31:0] ev_start_q;
  logic [15:0] ev_width_q, ev_peak_q;
  logic [31:0] ev_sum_q;
  logic        ev_open, ev_acc, push;
  rec_t        push_rec;

  logic        samp_flag, samp_gap;
  logic [15:0] wid_inc, peak_acc;
  logic [31:0] sum_acc;

  assign samp_flag = laser_start_i & filter_vld_i & filter_acc_result_i;
  assign samp_gap  = laser_start_i & filter_vld_i & ~filter_acc_result_i;
  assign wid_inc   = ev_width_q + 16'd1;
  assign peak_acc  = max16(ev_peak_q, filter_data_i);
  assign sum_acc   = ev_sum_q + {16'd0, filter_data_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      laser_q <= 1'b0;
    end else begin
      state_q <= state_d;
      laser_q <= laser_start_i;
      if (!laser_start_i)    idx_q <= '0;
      else if (filter_vld_i) idx_q <= idx_q + 32'd1;
    end
  end

  // Open-event accumulators: only meaningful while ACTIVE, so left unreset.
  always_ff @(posedge clk_i) begin
    if (ev_open) begin
      ev_start_q <= idx_q;
      ev_width_q <= 16'd1;
      ev_peak_q  <= filter_data_i;
      ev_sum_q   <= {16'd0, filter_data_i};
    end else if (ev_acc) begin
      ev_width_q <= wid_inc;
      ev_peak_q  <= peak_acc;
      ev_sum_q   <= sum_acc;
    end
  end

  always_comb begin
    state_d  = state_q;
    ev_open  = 1'b0;
    ev_acc   = 1'b0;
    push     = 1'b0;
    push_rec = '0;
    case (state_q)
      S_IDLE: begin
        if (samp_flag) begin
          ev_open = 1'b1;
          if (MAXW_C == 16'd1) begin
            push     = 1'b1;
            push_rec = '{start: idx_q, width: 16'd1, peak: filter_data_i,
                         sum: {16'd0, filter_data_i}, trunc: 1'b1};
            state_d  = S_HOLD;
          end else begin
            state_d  = S_ACTIVE;
          end
        end
      end
      S_ACTIVE: begin
        if (!laser_start_i) begin
          push     = 1'b1;
          push_rec = '{start: ev_start_q, width: ev_width_q, peak: ev_peak_q,
                       sum: ev_sum_q, trunc: 1'b1};
          state_d  = S_IDLE;
        end else if (samp_flag) begin
          ev_acc = 1'b1;
          if (wid_inc == MAXW_C) begin
            push     = 1'b1;
            push_rec = '{start: ev_start_q, width: wid_inc, peak: peak_acc,
                         sum: sum_acc, trunc: 1'b1};
            state_d  = S_HOLD;
          end
        end else if (samp_gap) begin
          push     = 1'b1;
          push_rec = '{start: ev_start_q, width: ev_width_q, peak: ev_peak_q,
                       sum: ev_sum_q, trunc: 1'b0};
          state_d  = S_IDLE;
        end
      end
      S_HOLD: begin
        if (!laser_start_i || samp_gap) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  rec_t            mem [FIFO_DEPTH];
  rec_t            head_q;
  logic [AW-1:0]   wr_q, rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d, kept;
  logic [15:0]     drop_q;
  logic            pop, full, push_ok, drop;

  assign pop     = (cnt_q != '0) & event_ready_i;
  assign full    = (cnt_q == DEPTH_C);
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign kept    = cnt_q - (AW+1)'(pop);
  assign cnt_d   = kept + (AW+1)'(push_ok);
  assign rd_d    = rd_q + AW'(pop);

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_q] <= push_rec;
  end

  // Head register: bypass the pushed record when the FIFO would otherwise be empty.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      drop_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (cnt_d != '0) head_q <= (kept == '0) ? push_rec : mem[rd_d];
      if (laser_start_i && !laser_q) drop_q <= '0;
      else if (drop)                 drop_q <= sat_inc16(drop_q);
    end
  end

  assign event_vld_o   = (cnt_q != '0);
  assign event_start_o = head_q.start;
  assign event_width_o = head_q.width;
  assign event_peak_o  = head_q.peak;
  assign event_sum_o   = head_q.sum;
  assign event_trunc_o = head_q.trunc;
  assign drop_cnt_o    = drop_q;

endmodule
